// File: rtl/l1_trig_pkg.sv
// Shared types and defaults for the L1 trigger merge block.
package l1_trig_pkg;
  localparam int NBEAMS_DEFAULT    = 2;
  localparam int TIME_BITS_DEFAULT = 16;

  typedef struct packed {
    logic [TIME_BITS_DEFAULT-1:0] ts;
    logic [NBEAMS_DEFAULT-1:0]    mask;
  } trig_word_t;

  localparam int TRIG_WORD_W = $bits(trig_word_t);
endpackage

// File: rtl/l1_trig_fifo.sv
// Synchronous first-word-fall-through FIFO; dout is zero while empty.
module l1_trig_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr,
  output logic             full,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             rd
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_rd;
  logic             w_wr;

  assign full  = (r_count == FULL_CNT);
  assign valid = (r_count != '0);
  assign dout  = valid ? r_mem[r_rd_ptr] : '0;

  // A write into a full FIFO is still taken when the head leaves on the same edge.
  assign w_rd = rd & valid;
  assign w_wr = wr & (~full | w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/l1_trig_merge.sv
// Per-beam holdoff/enable masking, same-cycle merge into timestamped words,
// FIFO buffering toward the TURF link with dropped-word accounting.
module l1_trig_merge
  import l1_trig_pkg::*;
#(
  parameter int NBEAMS       = NBEAMS_DEFAULT,
  parameter int HOLDOFF_BITS = 8,
  parameter int TIME_BITS    = TIME_BITS_DEFAULT,
  parameter int FIFO_DEPTH   = 4,
  parameter int DROP_BITS    = 16
) (
  input  logic                        ifclk,
  input  logic                        ifclk_rst_i,
  input  logic [NBEAMS-1:0]           trigger_i,
  input  logic [NBEAMS-1:0]           beam_en_i,
  input  logic [HOLDOFF_BITS-1:0]     holdoff_i,
  output logic [TIME_BITS+NBEAMS-1:0] trig_tdata,
  output logic                        trig_tvalid,
  input  logic                        trig_tready,
  output logic                        overflow_o,
  output logic [DROP_BITS-1:0]        dropped_o
);
  localparam int W = TIME_BITS + NBEAMS;

  logic [TIME_BITS-1:0]    r_ts;
  logic [HOLDOFF_BITS-1:0] r_hold [NBEAMS];
  logic [NBEAMS-1:0]       w_fire;
  logic                    r_push;
  logic [W-1:0]            r_word;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_drop;
  logic                    r_overflow;
  logic [DROP_BITS-1:0]    r_dropped;

  always_comb begin
    w_fire = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      w_fire[b] = trigger_i[b] & beam_en_i[b] & (r_hold[b] == '0);
    end
  end

  // Link handshake: a word transfers on any edge where trig_tvalid and trig_tready
  // are both high; trig_tdata holds steady while valid waits for ready.
  assign w_pop  = trig_tvalid & trig_tready;
  assign w_drop = r_push & w_full & ~w_pop;

  always_ff @(posedge ifclk) begin
    if (ifclk_rst_i) begin
      r_ts       <= '0;
      r_push     <= 1'b0;
      r_word     <= '0;
      r_overflow <= 1'b0;
      r_dropped  <= '0;
      for (int b = 0; b < NBEAMS; b++) r_hold[b] <= '0;
    end else begin
      r_ts   <= r_ts + 1'b1;
      r_push <= |w_fire;
      r_word <= {r_ts, w_fire};
      // Holdoff runs from the fire itself, whether or not the word is buffered.
      for (int b = 0; b < NBEAMS; b++) begin
        if (w_fire[b])             r_hold[b] <= holdoff_i;
        else if (r_hold[b] != '0)  r_hold[b] <= r_hold[b] - 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropped != '1) r_dropped <= r_dropped + 1'b1;
      end
    end
  end

  l1_trig_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ifclk),
    .rst   (ifclk_rst_i),
    .din   (r_word),
    .wr    (r_push),
    .full  (w_full),
    .dout  (trig_tdata),
    .valid (trig_tvalid),
    .rd    (trig_tready)
  );

  assign overflow_o = r_overflow;
  assign dropped_o  = r_dropped;
endmodule

// File: tb/tb_l1_trig_merge.sv
// Bench for l1_trig_merge: cycle model feeding an expected-word queue plus directed checks.
module tb_l1_trig_merge;
  import l1_trig_pkg::*;

  localparam int NB    = 2;
  localparam int HB    = 8;
  localparam int TB    = 16;
  localparam int DEPTH = 4;
  localparam int DB    = 16;
  localparam int W     = TB + NB;

  // clock / reset
  logic          ifclk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] trig = '0;
  logic [NB-1:0] en = '1;
  logic [HB-1:0] hold_len = '0;
  logic          tready = 1'b0;
  logic [W-1:0]  tdata;
  logic          tvalid;
  logic          ovf;
  logic [DB-1:0] dropped;

  always #5 ifclk = ~ifclk;

  l1_trig_merge #(
    .NBEAMS(NB), .HOLDOFF_BITS(HB), .TIME_BITS(TB), .FIFO_DEPTH(DEPTH), .DROP_BITS(DB)
  ) dut (
    .ifclk       (ifclk),
    .ifclk_rst_i (rst),
    .trigger_i   (trig),
    .beam_en_i   (en),
    .holdoff_i   (hold_len),
    .trig_tdata  (tdata),
    .trig_tvalid (tvalid),
    .trig_tready (tready),
    .overflow_o  (ovf),
    .dropped_o   (dropped)
  );

  // scoreboard
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] want_q[$];

  logic [TB-1:0] m_ts;
  int            m_hold [NB];
  logic          m_stage_v;
  logic [W-1:0]  m_stage_w;
  int            m_drop;
  logic          m_ovf;
  logic          mon_en = 1'b0;
  logic          stall;
  logic [W-1:0]  stall_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mkw(input logic [TB-1:0] ts, input logic [NB-1:0] m);
    trig_word_t w;
    w.ts   = ts;
    w.mask = m;
    return w;
  endfunction

  // Reference model, advanced on each rising edge with the inputs seen at that edge.
  always @(posedge ifclk) begin : model
    logic [NB-1:0] f;
    int            sz;
    logic          pop;
    if (rst) begin
      m_ts      = '0;
      m_stage_v = 1'b0;
      m_stage_w = '0;
      m_drop    = 0;
      m_ovf     = 1'b0;
      stall     = 1'b0;
      exp_q.delete();
      for (int b = 0; b < NB; b++) m_hold[b] = 0;
    end else begin
      stall      = tvalid && !tready;
      stall_data = tdata;
      if (tvalid && tready) got_q.push_back(tdata);
      sz  = exp_q.size();
      pop = (sz > 0) && tready;
      if (pop) void'(exp_q.pop_front());
      if (m_stage_v) begin
        if (sz < DEPTH || pop) exp_q.push_back(m_stage_w);
        else begin
          if (m_drop < 65535) m_drop++;
          m_ovf = 1'b1;
        end
      end
      for (int b = 0; b < NB; b++) begin
        f[b] = trig[b] && en[b] && (m_hold[b] == 0);
        if (f[b])                m_hold[b] = int'(hold_len);
        else if (m_hold[b] > 0)  m_hold[b] = m_hold[b] - 1;
      end
      m_stage_v = |f;
      m_stage_w = {m_ts, f};
      m_ts      = m_ts + 1'b1;
    end
  end

  always @(negedge ifclk) begin
    if (mon_en) begin
      chk("tvalid", tvalid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("tdata", tdata, exp_q[0]);
      chk("dropped", dropped, m_drop);
      chk("overflow", ovf, m_ovf);
      if (stall) begin
        chk("stall_valid", tvalid, 1);
        chk("stall_data", tdata, stall_data);
      end
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge ifclk);
    #1;
  endtask

  task automatic wait_ts(input logic [TB-1:0] t);
    int n = 0;
    while (m_ts != t && n < 70000) begin
      cycle();
      n++;
    end
    chk("wait_ts", m_ts, t);
  endtask

  task automatic drain();
    tready = 1'b1;
    repeat (12) cycle();
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_count"}, got_q.size(), want_q.size());
    for (int i = 0; i < want_q.size(); i++) begin
      if (i < got_q.size()) chk(tag, got_q[i], want_q[i]);
    end
    want_q.delete();
    got_q.delete();
  endtask

  initial begin
    logic [TB-1:0] t0;
    logic [TB-1:0] t1;
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_overflow", ovf, 0);
    chk("rst_dropped", dropped, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    got_q.delete();

    // holdoff
    hold_len = 8'd5;
    tready   = 1'b1;
    wait_ts(16'd10);
    trig = 2'b01;
    repeat (20) cycle();
    trig = 2'b00;
    drain();
    want_q.push_back(mkw(16'd10, 2'b01));
    want_q.push_back(mkw(16'd16, 2'b01));
    want_q.push_back(mkw(16'd22, 2'b01));
    want_q.push_back(mkw(16'd28, 2'b01));
    check_got("holdoff");

    // merge and mask
    hold_len = 8'd0;
    wait_ts(16'd50);
    trig = 2'b11;
    cycle();
    trig = 2'b00;
    wait_ts(16'd60);
    en   = 2'b10;
    trig = 2'b11;
    cycle();
    trig = 2'b00;
    wait_ts(16'd70);
    trig = 2'b01;
    cycle();
    trig = 2'b00;
    en   = 2'b11;
    drain();
    want_q.push_back(mkw(16'd50, 2'b11));
    want_q.push_back(mkw(16'd60, 2'b10));
    check_got("merge");

    // single fire latency
    wait_ts(16'd100);
    trig = 2'b01;
    cycle();
    trig = 2'b00;
    chk("lat1_tvalid", tvalid, 0);
    cycle();
    chk("lat2_tvalid", tvalid, 1);
    chk("lat2_tdata", tdata, mkw(16'd100, 2'b01));
    cycle();
    chk("lat3_tvalid", tvalid, 0);
    drain();
    want_q.push_back(mkw(16'd100, 2'b01));
    check_got("single");

    // overflow, then full with a same-cycle pop
    tready = 1'b0;
    t0     = m_ts;
    trig   = 2'b01;
    repeat (7) cycle();
    trig = 2'b00;
    repeat (3) cycle();
    chk("ovf_dropped", dropped, 3);
    chk("ovf_flag", ovf, 1);
    t1   = m_ts;
    trig = 2'b01;
    cycle();
    trig   = 2'b00;
    tready = 1'b1;
    cycle();
    chk("fullpop_dropped", dropped, 3);
    drain();
    for (int i = 0; i < 4; i++) want_q.push_back(mkw(t0 + TB'(i), 2'b01));
    want_q.push_back(mkw(t1, 2'b01));
    check_got("overflow");

    // reset with words queued
    tready = 1'b0;
    trig   = 2'b01;
    repeat (2) cycle();
    trig = 2'b00;
    repeat (3) cycle();
    chk("prerst_tvalid", tvalid, 1);
    rst = 1'b1;
    cycle();
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_dropped", dropped, 0);
    chk("midrst_overflow", ovf, 0);
    rst = 1'b0;
    got_q.delete();
    trig = 2'b01;
    cycle();
    trig = 2'b00;
    drain();
    want_q.push_back(mkw(16'd0, 2'b01));
    check_got("rst_ts");

    // random traffic, checked by the model each cycle
    hold_len = HB'($urandom_range(0, 3));
    repeat (300) begin
      trig   = NB'($urandom_range(0, 3));
      en     = NB'($urandom_range(0, 3));
      tready = 1'($urandom_range(0, 1));
      cycle();
    end
    trig     = 2'b00;
    en       = 2'b11;
    hold_len = 8'd0;
    drain();
    got_q.delete();

    // timestamp wrap
    wait_ts(16'hFFFF);
    trig = 2'b01;
    repeat (2) cycle();
    trig = 2'b00;
    drain();
    want_q.push_back(mkw(16'hFFFF, 2'b01));
    want_q.push_back(mkw(16'h0000, 2'b01));
    check_got("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/l1_trig_merge.md
Name: l1_trig_merge

Overview:
- Sits directly downstream of the L1 beam trigger stage, in the ifclk domain.
- Consumes the per-beam trigger pulses and applies per-beam holdoff and enable masking.
- Merges all beams that fire in the same cycle into one timestamped trigger word.
- Buffers trigger words in a small FIFO toward the TURF link using a valid/ready handshake, and counts words dropped on overflow.

Parameters:
NBEAMS, 2, number of beam trigger inputs
HOLDOFF_BITS, 8, width of the per-beam holdoff counter
TIME_BITS, 16, width of the free-running timestamp
FIFO_DEPTH, 4, trigger-word FIFO depth; power of 2, at least 2
DROP_BITS, 16, width of the dropped-word counter

Ports:
ifclk  in  1  sole clock; all logic on its rising edge
ifclk_rst_i  in  1  synchronous, active-high reset
trigger_i  in  NBEAMS  per-beam trigger pulses (trigger_o of L1 stage)
beam_en_i  in  NBEAMS  per-beam enable; 0 masks the beam
holdoff_i  in  HOLDOFF_BITS  holdoff length in ifclk cycles; quasi-static
trig_tdata  out  TIME_BITS+NBEAMS  {timestamp, beam mask}; beam mask in LSBs
trig_tvalid  out  1  trigger word valid
trig_tready  in  1  consumer ready
overflow_o  out  1  sticky: at least one word dropped since reset
dropped_o  out  DROP_BITS  saturating count of dropped words

Behaviour:
- Reset values:
  - trig_tvalid=0, trig_tdata=0, overflow_o=0, dropped_o=0.
  - FIFO empty; all holdoff counters 0; timestamp 0.
- Timestamp:
  - Increments by 1 every cycle after reset and wraps from 2^TIME_BITS-1 to 0.
  - The value captured is the timestamp in the cycle trigger_i is sampled.
- Per-beam fire, beam b in cycle N:
  - fire[b] = trigger_i[b] & beam_en_i[b] & (hold[b]==0).
  - When fire[b] is set, hold[b] loads holdoff_i.
  - Otherwise, when hold[b]!=0, hold[b] decrements by 1.
  - holdoff_i=0: no holdoff; a beam may fire every cycle.
  - holdoff_i=H: after a fire in cycle N, the next fire is possible at N+H+1 at the earliest.
- Merge:
  - If fire!=0 in cycle N, the word {ts(N), fire} is registered and pushed to the FIFO at edge N+1.
  - Pushed words appear on trig_tdata with trig_tvalid=1 no earlier than cycle N+2.
  - Minimum latency is 2 cycles when the FIFO is empty.
- FIFO:
  - First-word-fall-through ordering; words are strictly in order.
  - Pop occurs when trig_tvalid & trig_tready.
  - While trig_tvalid=1 and trig_tready=0, trig_tdata is stable.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves the occupancy unchanged.
- Drop:
  - A push that is not accepted discards the word.
  - dropped_o increments by 1 and saturates at all-ones.
  - overflow_o is set and stays set until reset.
  - A dropped word still leaves the holdoff counters loaded; holdoff is applied at fire, independent of buffering.
- beam_en_i changes take effect in the same cycle they are sampled; a masked beam's holdoff counter keeps decrementing.
- Reset mid-operation:
  - All state returns to reset values on the next edge and FIFO contents are discarded.
  - trig_tvalid drops in the cycle after reset is asserted, regardless of trig_tready.
- Two beams firing in the same cycle produce exactly one word, with both mask bits set.

Decomposition:
- Shared package l1_trig_pkg:
  - NBEAMS_DEFAULT.
  - trig_word_t packed struct {logic [TIME_BITS-1:0] ts; logic [NBEAMS-1:0] mask;}.
  - TRIG_WORD_W constant.
- One sub-module: l1_trig_fifo, a synchronous FWFT FIFO.
  - Ports: clk, rst, din, wr, full, dout, valid, rd.
  - Parameters WIDTH and DEPTH.
  - Occupancy is held in a log2(DEPTH)+1-bit counter.
- The holdoff, merge, timestamp and drop logic stays in the top level.

Test Plan:
- Single fire: holdoff_i=0, trig_tready=1, trigger_i=2'b01 for one cycle at ts=100 -> exactly one word {100, 2'b01} with trig_tvalid at cycle +2, then trig_tvalid=0.
- Holdoff: holdoff_i=5, trigger_i[0] held high 20 cycles from ts=10 -> words at ts=10, 16, 22, 28 only, each mask 2'b01.
- Merge and mask:
  - trigger_i=2'b11 at ts=50 -> one word {50, 2'b11}.
  - beam_en_i=2'b10, trigger_i=2'b11 at ts=60 -> {60, 2'b10}.
  - trigger_i=2'b01 only with beam 0 masked -> no word.
- Backpressure/overflow:
  - trig_tready=0, holdoff_i=0, trigger_i=2'b01 for 7 consecutive cycles -> FIFO holds the first 4 words; dropped_o=3; overflow_o=1.
  - Then trig_tready=1 -> those 4 words emerge in order with tdata stable while stalled.
- Full with simultaneous pop: FIFO full, trig_tready=1 and a new fire in the same cycle -> word accepted, dropped_o unchanged.
- Wrap and reset:
  - Timestamp wraps 0xFFFF->0x0000 and a fire at ts=0xFFFF reports 0xFFFF.
  - Asserting ifclk_rst_i with 2 words queued -> trig_tvalid=0 next cycle, dropped_o=0, overflow_o=0, timestamp restarts at 0.
